// File: rtl/alu_pkg.sv
// Shared encodings for the execute sequencer: instruction op/ext codes, flag
// indices, PSR update masks, FSM states, operand-B format classes and decoder.
package alu_pkg;

  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hF;

  localparam logic [3:0] EXT_AND    = 4'h1;
  localparam logic [3:0] EXT_OR     = 4'h2;
  localparam logic [3:0] EXT_XOR    = 4'h3;
  localparam logic [3:0] EXT_ADD    = 4'h5;
  localparam logic [3:0] EXT_SUB    = 4'h9;
  localparam logic [3:0] EXT_CMP    = 4'hB;
  localparam logic [3:0] EXT_MOV    = 4'hD;
  localparam logic [3:0] EXT_LSH    = 4'h4;
  localparam logic [3:0] EXT_ASHU   = 4'h6;
  localparam logic [3:0] EXT_LSHI_L = 4'h0;
  localparam logic [3:0] EXT_LSHI_R = 4'h1;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [4:0] PSR_MASK_NONE  = 5'b00000;
  localparam logic [4:0] PSR_MASK_ARITH = (5'b1 << FLAG_C) | (5'b1 << FLAG_F);
  localparam logic [4:0] PSR_MASK_CMP   = (5'b1 << FLAG_L) | (5'b1 << FLAG_Z) | (5'b1 << FLAG_N);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    FMT_REG     = 3'd0,
    FMT_SIMM    = 3'd1,
    FMT_ZIMM    = 3'd2,
    FMT_LUI     = 3'd3,
    FMT_SHIMM   = 3'd4,
    FMT_ILLEGAL = 3'd5
  } fmt_t;

  typedef struct packed {
    fmt_t       fmt;
    logic       legal;
    logic       writes;
    logic [4:0] psr_mask;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] instr);
    dec_t       d;
    logic [3:0] op;
    logic [3:0] ext;
    op         = instr[15:12];
    ext        = instr[7:4];
    d.fmt      = FMT_ILLEGAL;
    d.legal    = 1'b0;
    d.writes   = 1'b0;
    d.psr_mask = PSR_MASK_NONE;
    case (op)
      OP_REG: begin
        if (ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_SUB, EXT_CMP, EXT_MOV}) begin
          d.fmt   = FMT_REG;
          d.legal = 1'b1;
        end
        if (ext == EXT_ADD || ext == EXT_SUB) d.psr_mask = PSR_MASK_ARITH;
        if (ext == EXT_CMP) d.psr_mask = PSR_MASK_CMP;
      end
      OP_ADDI, OP_SUBI: begin
        d.fmt      = FMT_SIMM;
        d.legal    = 1'b1;
        d.psr_mask = PSR_MASK_ARITH;
      end
      OP_CMPI: begin
        d.fmt      = FMT_SIMM;
        d.legal    = 1'b1;
        d.psr_mask = PSR_MASK_CMP;
      end
      OP_MOVI: begin
        d.fmt   = FMT_SIMM;
        d.legal = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.fmt   = FMT_ZIMM;
        d.legal = 1'b1;
      end
      OP_LUI: begin
        d.fmt   = FMT_LUI;
        d.legal = 1'b1;
      end
      OP_SHIFT: begin
        if (ext inside {EXT_LSH, EXT_ASHU}) begin
          d.fmt   = FMT_REG;
          d.legal = 1'b1;
        end else if (ext inside {EXT_LSHI_L, EXT_LSHI_R}) begin
          d.fmt   = FMT_SHIMM;
          d.legal = 1'b1;
        end
      end
      default: ;
    endcase
    // Compares only update flags; illegal encodings never write.
    d.writes = d.legal && (d.psr_mask != PSR_MASK_CMP);
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Operand-B selection: register operand or immediate extended per format class.
module imm_gen
  import alu_pkg::*;
(
  input  logic [7:0]  instr_lo,
  input  logic [15:0] rf_rdata_b,
  input  logic [2:0]  fmt,
  output logic [15:0] b
);

  always_comb begin
    b = 16'h0000;
    case (fmt)
      FMT_REG:   b = rf_rdata_b;
      FMT_SIMM:  b = {{8{instr_lo[7]}}, instr_lo};
      FMT_ZIMM:  b = {8'h00, instr_lo};
      FMT_LUI:   b = {instr_lo, 8'h00};
      FMT_SHIMM: b = {12'h000, instr_lo[3:0]};
      default:   b = 16'h0000;
    endcase
  end

endmodule

// File: rtl/exec_controller.sv
// Four-state execute sequencer: latch instruction, decode and read operands,
// drive the ALU, then write back the result and update the PSR.
module exec_controller
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [7:0]  alu_Opcode,
  input  logic [15:0] alu_C,
  input  logic [4:0]  alu_Flags,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [4:0]  psr,
  output logic        illegal,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  state_t      state;
  logic [15:0] ir;
  dec_t        dec;
  logic [15:0] b_next;
  logic [4:0]  flags_q;

  // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
  // ready is high exactly in IDLE and instr is ignored otherwise.
  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign dbg_state   = state;
  assign rf_raddr_a  = ir[11:8];
  assign rf_raddr_b  = ir[3:0];
  assign dec         = decode(ir);

  imm_gen u_imm_gen (
    .instr_lo   (ir[7:0]),
    .rf_rdata_b (rf_rdata_b),
    .fmt        (dec.fmt),
    .b          (b_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ir         <= 16'h0000;
      alu_A      <= 16'h0000;
      alu_B      <= 16'h0000;
      alu_Opcode <= 8'h00;
      rf_we      <= 1'b0;
      rf_waddr   <= 4'h0;
      rf_wdata   <= 16'h0000;
      psr        <= 5'b00000;
      illegal    <= 1'b0;
      flags_q    <= 5'b00000;
    end else begin
      rf_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_A      <= rf_rdata_a;
          alu_B      <= b_next;
          alu_Opcode <= {ir[15:12], ir[7:4]};
          if (!dec.legal) illegal <= 1'b1;
          state      <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          flags_q  <= alu_Flags;
          rf_wdata <= alu_C;
          rf_waddr <= ir[11:8];
          rf_we    <= dec.writes;
          state    <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          psr   <= (psr & ~dec.psr_mask) | (flags_q & dec.psr_mask);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
